register_split: RTL
===================

Name: register_split

Overview:
- Reader-side counterpart to the team's half-loadable split register.
- Accepts a full N-bit word over a valid/ready handshake and emits it as one or two N/2-bit halves over a second valid/ready handshake.
- Each half carries a tag saying which half it is, so a downstream split register can drive its high/low load strobes directly from the tag.
- A per-word mask selects which halves are sent. A counter tracks completed words.

Parameters:
- N, 16, full word width; must be even and at least 4.
- HIGH_FIRST, 1, 1 = send the high half before the low half; 0 = send low before high.

Ports:
- clk  in  1  rising-edge clock
- clear_n  in  1  asynchronous active-low reset
- in_word  in  N  word to split
- in_mask  in  2  bit1 = send high half, bit0 = send low half
- in_valid  in  1  in_word and in_mask are valid
- in_ready  out  1  block can take a word this cycle
- out_half  out  N/2  half-word data
- out_hi  out  1  1 = out_half is the high half, 0 = it is the low half
- out_last  out  1  this is the final half of the current word
- out_valid  out  1  out_half, out_hi and out_last are valid
- out_ready  in  1  consumer accepts the half this cycle
- busy  out  1  a word is held, i.e. state is not IDLE
- words_sent  out  8  count of completed words

Behaviour:
- Reset: clear_n low, asynchronous.
  - Forces state to IDLE.
  - out_valid=0, out_half=0, out_hi=0, out_last=0, busy=0, words_sent=0.
  - Any held word is discarded.
  - in_ready reads 1 once clear_n is high.
- States: IDLE, FIRST, SECOND.
- Input handshake:
  - A word is accepted on a clock edge where in_valid && in_ready.
  - in_ready = (state==IDLE) || (out_valid && out_ready && out_last). It is combinational, which allows back-to-back words.
- On acceptance, the word and mask are latched and the next state is chosen:
  - mask 11 -> FIRST. First half is high if HIGH_FIRST=1, otherwise low. out_last=0.
  - mask 10 -> FIRST with the high half only. out_hi=1, out_last=1.
  - mask 01 -> FIRST with the low half only. out_hi=0, out_last=1.
  - mask 00 -> word is consumed and nothing is emitted. State stays or returns to IDLE. words_sent is unchanged.
- Latency: a word accepted at edge t has its first half at out_valid=1 in the cycle following t.
- Output hold: all out_* signals are registered.
  - While out_valid && !out_ready, out_half, out_hi and out_last must not change.
  - out_valid must not drop until the half is accepted.
- Transitions:
  - FIRST with out_last=0, half accepted -> SECOND. The next cycle presents the other half with out_last=1.
  - FIRST or SECOND with out_last=1, half accepted:
    - words_sent increments, wrapping 255 -> 0.
    - If a new word is accepted on the same edge, go to FIRST, or IDLE for mask 00.
    - Otherwise go to IDLE with out_valid=0.
- Throughput, mask 11: 2 cycles per word sustained with out_ready=1 and in_valid=1. Bubble-free.
- Throughput, single-half masks: 1 cycle per word sustained.
- In IDLE, out_half holds its last value; it is don't-care for checking.
- in_word and in_mask changes are ignored while in_ready=0.
- words_sent increments exactly once per word whose last half was accepted.
- busy=1 in FIRST and SECOND.

Test Plan:
- Reset then idle: clear_n low mid-cycle -> all outputs 0 immediately. After release, in_ready=1, busy=0.
- Single word, HIGH_FIRST=1, in_word=16'hA55A, mask 11, out_ready held 0 for 3 cycles:
  - out_half=8'hA5, out_hi=1, out_last=0 stable for 3 cycles.
  - Then 8'h5A, out_hi=0, out_last=1.
  - words_sent=1.
- Back-to-back, out_ready=1, three words 16'h1122, 16'h3344, 16'h5566 with mask 11:
  - Halves 11,22,33,44,55,66 appear on 6 consecutive cycles.
  - in_ready pulses high on the last-half cycles.
  - words_sent=3.
- Masks:
  - 16'hBEEF mask 10 -> single half EF? no: single half BE with out_hi=1, out_last=1.
  - 16'hBEEF mask 01 -> single half EF with out_hi=0, out_last=1.
  - Mask 00 -> no out_valid and words_sent unchanged.
- HIGH_FIRST=0, 16'hCAFE mask 11 -> FE (out_hi=0), then CA (out_hi=1, out_last=1).
- Wrap and reset:
  - 256 single-half words -> words_sent returns to 0.
  - clear_n low while in SECOND with out_ready=0 -> out_valid=0, IDLE, words_sent=0. The next word is split correctly.

Source files
------------

// File: rtl/register_split.sv
// rtl/register_split.sv - splits an N-bit word into tagged N/2-bit halves over valid/ready
module register_split #(
   parameter int N          = 16,
   parameter bit HIGH_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic [N-1:0]     in_word,
   input  logic [1:0]       in_mask,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [N/2-1:0]   out_half,
   output logic             out_hi,
   output logic             out_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic [7:0]       words_sent
);

   localparam int H = N / 2;

   typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

   state_t       state, state_nx;
   logic [H-1:0] pend_q, pend_nx;
   logic [H-1:0] half_nx;
   logic         hi_nx, last_nx, valid_nx;
   logic [7:0]   cnt_nx;
   logic         fire, done, accept;
   logic [H-1:0] word_hi, word_lo;

   assign word_hi  = in_word[N-1:H];
   assign word_lo  = in_word[H-1:0];
   assign fire     = out_valid && out_ready;
   assign done     = fire && out_last;
   assign in_ready = (state == IDLE) || done;
   assign accept   = in_valid && in_ready;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state      <= IDLE;
         pend_q     <= '0;
         out_half   <= '0;
         out_hi     <= 1'b0;
         out_last   <= 1'b0;
         out_valid  <= 1'b0;
         words_sent <= 8'd0;
      end else begin
         state      <= state_nx;
         pend_q     <= pend_nx;
         out_half   <= half_nx;
         out_hi     <= hi_nx;
         out_last   <= last_nx;
         out_valid  <= valid_nx;
         words_sent <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      pend_nx  = pend_q;
      half_nx  = out_half;
      hi_nx    = out_hi;
      last_nx  = out_last;
      valid_nx = out_valid;
      cnt_nx   = words_sent;

      if (fire && !out_last) begin
         // pend_q holds the half that was not sent first
         state_nx = SECOND;
         half_nx  = pend_q;
         hi_nx    = ~out_hi;
         last_nx  = 1'b1;
      end else begin
         if (done) begin
            cnt_nx   = words_sent + 8'd1;
            state_nx = IDLE;
            valid_nx = 1'b0;
         end
         if (accept) begin
            case (in_mask)
               2'b11: begin
                  state_nx = FIRST;
                  valid_nx = 1'b1;
                  hi_nx    = HIGH_FIRST;
                  last_nx  = 1'b0;
                  half_nx  = HIGH_FIRST ? word_hi : word_lo;
                  pend_nx  = HIGH_FIRST ? word_lo : word_hi;
               end
               2'b10: begin
                  state_nx = FIRST;
                  valid_nx = 1'b1;
                  hi_nx    = 1'b1;
                  last_nx  = 1'b1;
                  half_nx  = word_hi;
               end
               2'b01: begin
                  state_nx = FIRST;
                  valid_nx = 1'b1;
                  hi_nx    = 1'b0;
                  last_nx  = 1'b1;
                  half_nx  = word_lo;
               end
               default: begin
                  state_nx = IDLE;
                  valid_nx = 1'b0;
               end
            endcase
         end
      end
   end

endmodule
